// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the register-bank responder.
package reg_bank_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Encoding of rsp_err_h.
  localparam logic OK       = 1'b0;
  localparam logic ERR_ADDR = 1'b1;

endpackage

// File: rtl/reg_bank_responder.sv
// Register bank with a single-outstanding request/response bus interface,
// parallel register export and per-register write strobes.
module reg_bank_responder
  import reg_bank_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    NUM_REGS    = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rsth,
  input  logic                           req_valid_h,
  output logic                           req_ready_h,
  input  logic                           req_write_h,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  output logic                           rsp_valid_h,
  input  logic                           rsp_ready_h,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err_h,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [IDX_W-1:0]      idx;
  logic                  addr_ok;
  logic                  req_fire;
  logic                  rsp_fire;

  assign idx      = req_addr[IDX_W-1:0];
  assign addr_ok  = int'(req_addr) < NUM_REGS;
  assign req_fire = req_valid_h & req_ready_h;
  assign rsp_fire = rsp_valid_h & rsp_ready_h;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rsth) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    req_ready_h = 1'b0;
    rsp_valid_h = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready_h = ~rsth;
        if (req_valid_h && !rsth) state_next = RESP;
      end
      RESP: begin
        rsp_valid_h = 1'b1;
        if (rsp_ready_h) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the register array is architecturally visible on regs_o, so it is
  // reset explicitly; a plain RAM holding no reset-visible state would not be.
  always_ff @(posedge clk) begin
    if (rsth) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
    end else if (req_fire && req_write_h && addr_ok) begin
      regs[idx] <= req_wdata;
    end
  end

  // Response buffer: captured on request acceptance, cleared once consumed.
  always_ff @(posedge clk) begin
    if (rsth) begin
      rsp_rdata  <= '0;
      rsp_err_h  <= OK;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (req_fire) begin
        if (!addr_ok) begin
          rsp_rdata <= '0;
          rsp_err_h <= ERR_ADDR;
        end else if (req_write_h) begin
          rsp_rdata  <= '0;
          rsp_err_h  <= OK;
          wr_pulse_o <= NUM_REGS'(1) << idx;
        end else begin
          rsp_rdata <= regs[idx];
          rsp_err_h <= OK;
        end
      end else if (rsp_fire) begin
        rsp_rdata <= '0;
        rsp_err_h <= OK;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_reg_bank_responder.sv
// Scoreboard bench for reg_bank_responder (DATA_WIDTH 16, ADDR_WIDTH 4, NUM_REGS 8).
module tb_reg_bank_responder;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 8;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rsth = 1'b1;
  logic             req_valid_h = 1'b0;
  logic             req_ready_h;
  logic             req_write_h = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [DW-1:0]    req_wdata = '0;
  logic             rsp_valid_h;
  logic             rsp_ready_h = 1'b0;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err_h;
  logic [NR*DW-1:0] regs_o;
  logic [NR-1:0]    wr_pulse_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] model [NR];
  rsp_t          sb [$];
  rsp_t          exp_rsp;

  reg_bank_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REGS   (NR),
    .RESET_VALUE('0)
  ) dut (
    .clk        (clk),
    .rsth       (rsth),
    .req_valid_h(req_valid_h),
    .req_ready_h(req_ready_h),
    .req_write_h(req_write_h),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid_h(rsp_valid_h),
    .rsp_ready_h(rsp_ready_h),
    .rsp_rdata  (rsp_rdata),
    .rsp_err_h  (rsp_err_h),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

  always #5 clk = ~clk;

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  function automatic void push_expected(input logic w, input logic [AW-1:0] a,
                                        input logic [DW-1:0] d);
    rsp_t r;
    if (int'(a) >= NR) begin
      r.rdata = '0;
      r.err   = 1'b1;
    end else if (w) begin
      r.rdata  = '0;
      r.err    = 1'b0;
      model[a] = d;
    end else begin
      r.rdata = model[a];
      r.err   = 1'b0;
    end
    sb.push_back(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request until accepted; returns one sample point after the accepting edge.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit hs;
    bit done;
    done        = 1'b0;
    req_valid_h = 1'b1;
    req_write_h = w;
    req_addr    = a;
    req_wdata   = d;
    for (int k = 0; k < 20 && !done; k++) begin
      hs = req_ready_h;
      tick();
      if (hs) done = 1'b1;
    end
    req_valid_h = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: addr %0d not accepted within 20 cycles, required acceptance", a);
    end else begin
      push_expected(w, a, d);
    end
  endtask

  task automatic consume();
    rsp_ready_h = 1'b1;
    tick();
    rsp_ready_h = 1'b0;
  endtask

  task automatic test_reset();
    rsth        = 1'b1;
    req_valid_h = 1'b1;
    req_write_h = 1'b1;
    req_addr    = 4'd1;
    req_wdata   = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (req_ready_h !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ready: got %b, required 0", req_ready_h);
      end
    end
    vectors++;
    if (rsp_valid_h !== 1'b0 || wr_pulse_o !== '0 || regs_o !== '0) begin
      miscompares++;
      $display("FAIL reset_state: rsp_valid %b wr_pulse %h regs %h, required 0/0/0",
               rsp_valid_h, wr_pulse_o, regs_o);
    end
    rsth        = 1'b0;
    req_valid_h = 1'b0;
    tick();
    vectors++;
    if (req_ready_h !== 1'b1 || rsp_valid_h !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ready %b rsp_valid %b, required 1/0", req_ready_h, rsp_valid_h);
    end
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic test_write_read();
    issue(1'b1, 4'd3, 16'hBEEF);
    exp_rsp = sb.pop_front();
    vectors++;
    if (rsp_valid_h !== 1'b1 || rsp_rdata !== exp_rsp.rdata || rsp_err_h !== exp_rsp.err) begin
      miscompares++;
      $display("FAIL wr_rsp: valid %b rdata %h err %b, required 1 %h %b",
               rsp_valid_h, rsp_rdata, rsp_err_h, exp_rsp.rdata, exp_rsp.err);
    end
    vectors++;
    if (wr_pulse_o !== 8'b0000_1000 || regs_o[63:48] !== 16'hBEEF || regs_o !== model_flat()) begin
      miscompares++;
      $display("FAIL wr_effect: pulse %b regs %h, required 00001000 %h", wr_pulse_o, regs_o, model_flat());
    end
    consume();
    vectors++;
    if (wr_pulse_o !== '0 || rsp_valid_h !== 1'b0 || rsp_rdata !== '0) begin
      miscompares++;
      $display("FAIL wr_after: pulse %b valid %b rdata %h, required 0 0 0", wr_pulse_o, rsp_valid_h, rsp_rdata);
    end
    issue(1'b0, 4'd3, '0);
    exp_rsp = sb.pop_front();
    vectors++;
    if (rsp_valid_h !== 1'b1 || rsp_rdata !== exp_rsp.rdata || rsp_err_h !== exp_rsp.err) begin
      miscompares++;
      $display("FAIL rd_rsp: valid %b rdata %h err %b, required 1 %h %b",
               rsp_valid_h, rsp_rdata, rsp_err_h, exp_rsp.rdata, exp_rsp.err);
    end
    consume();
  endtask

  task automatic test_out_of_range();
    issue(1'b1, 4'd9, 16'h1234);
    exp_rsp = sb.pop_front();
    vectors++;
    if (rsp_rdata !== exp_rsp.rdata || rsp_err_h !== exp_rsp.err || rsp_err_h !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_wr_rsp: rdata %h err %b, required %h %b", rsp_rdata, rsp_err_h, exp_rsp.rdata, exp_rsp.err);
    end
    vectors++;
    if (regs_o !== model_flat() || wr_pulse_o !== '0) begin
      miscompares++;
      $display("FAIL oor_wr_effect: regs %h pulse %b, required %h 0", regs_o, wr_pulse_o, model_flat());
    end
    consume();
    issue(1'b0, 4'd15, '0);
    exp_rsp = sb.pop_front();
    vectors++;
    if (rsp_rdata !== exp_rsp.rdata || rsp_err_h !== exp_rsp.err || rsp_err_h !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_rd_rsp: rdata %h err %b, required %h %b", rsp_rdata, rsp_err_h, exp_rsp.rdata, exp_rsp.err);
    end
    consume();
  endtask

  task automatic test_backpressure();
    issue(1'b1, 4'd0, 16'h00A5);
    void'(sb.pop_front());
    consume();
    issue(1'b0, 4'd0, '0);
    exp_rsp     = sb.pop_front();
    req_valid_h = 1'b1;
    req_write_h = 1'b1;
    req_addr    = 4'd1;
    req_wdata   = 16'h0077;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (rsp_valid_h !== 1'b1 || rsp_rdata !== exp_rsp.rdata || rsp_rdata !== 16'h00A5 || req_ready_h !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: valid %b rdata %h ready %b, required 1 %h 0",
                 i, rsp_valid_h, rsp_rdata, req_ready_h, exp_rsp.rdata);
      end
    end
    consume();
    vectors++;
    if (rsp_valid_h !== 1'b0 || req_ready_h !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: valid %b ready %b, required 0 1", rsp_valid_h, req_ready_h);
    end
    tick();
    req_valid_h = 1'b0;
    push_expected(1'b1, 4'd1, 16'h0077);
    exp_rsp = sb.pop_front();
    vectors++;
    if (rsp_valid_h !== 1'b1 || rsp_err_h !== exp_rsp.err || wr_pulse_o !== 8'b0000_0010 || regs_o !== model_flat()) begin
      miscompares++;
      $display("FAIL bp_second: valid %b err %b pulse %b regs %h, required 1 %b 00000010 %h",
               rsp_valid_h, rsp_err_h, wr_pulse_o, regs_o, exp_rsp.err, model_flat());
    end
    consume();
  endtask

  task automatic test_back_to_back();
    rsp_ready_h = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid_h = 1'b1;
      req_write_h = 1'b1;
      req_addr    = AW'(i);
      req_wdata   = DW'(16'h1000 + i);
      tick();
      push_expected(1'b1, AW'(i), DW'(16'h1000 + i));
      exp_rsp = sb.pop_front();
      vectors++;
      if (rsp_valid_h !== 1'b1 || req_ready_h !== 1'b0 || wr_pulse_o !== NR'(1 << i) || rsp_err_h !== exp_rsp.err) begin
        miscompares++;
        $display("FAIL b2b_accept%0d: valid %b ready %b pulse %b err %b, required 1 0 %b %b",
                 i, rsp_valid_h, req_ready_h, wr_pulse_o, rsp_err_h, NR'(1 << i), exp_rsp.err);
      end
      tick();
      vectors++;
      if (rsp_valid_h !== 1'b0 || req_ready_h !== 1'b1 || wr_pulse_o !== '0 || regs_o !== model_flat()) begin
        miscompares++;
        $display("FAIL b2b_gap%0d: valid %b ready %b pulse %b regs %h, required 0 1 0 %h",
                 i, rsp_valid_h, req_ready_h, wr_pulse_o, regs_o, model_flat());
      end
    end
    req_valid_h = 1'b0;
    rsp_ready_h = 1'b0;
  endtask

  task automatic test_mid_reset();
    issue(1'b1, 4'd2, 16'h5555);
    void'(sb.pop_front());
    vectors++;
    if (regs_o[47:32] !== 16'h5555) begin
      miscompares++;
      $display("FAIL mr_written: reg2 %h, required 5555", regs_o[47:32]);
    end
    rsth = 1'b1;
    tick();
    vectors++;
    if (rsp_valid_h !== 1'b0 || regs_o[47:32] !== 16'h0000 || regs_o !== '0) begin
      miscompares++;
      $display("FAIL mr_dropped: valid %b regs %h, required 0 0", rsp_valid_h, regs_o);
    end
    for (int i = 0; i < NR; i++) model[i] = '0;
    req_valid_h = 1'b1;
    req_write_h = 1'b1;
    req_addr    = 4'd4;
    req_wdata   = 16'hAAAA;
    tick();
    vectors++;
    if (regs_o !== '0 || rsp_valid_h !== 1'b0 || wr_pulse_o !== '0) begin
      miscompares++;
      $display("FAIL mr_coincident: regs %h valid %b pulse %b, required 0 0 0", regs_o, rsp_valid_h, wr_pulse_o);
    end
    req_valid_h = 1'b0;
    rsth        = 1'b0;
    tick();
    issue(1'b0, 4'd4, '0);
    exp_rsp = sb.pop_front();
    vectors++;
    if (rsp_rdata !== exp_rsp.rdata || rsp_err_h !== exp_rsp.err) begin
      miscompares++;
      $display("FAIL mr_readback: rdata %h err %b, required %h %b", rsp_rdata, rsp_err_h, exp_rsp.rdata, exp_rsp.err);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_bank_responder.md
Name: reg_bank_responder

Overview:
Bus-side responder for a bank of NUM_REGS read/write control registers, serving the read direction (and writes) of the SoC's register interface.
- Accepts one request at a time over a valid/ready handshake.
- Performs the write, or captures read data.
- Returns a buffered response over a second valid/ready handshake.
Register contents are exported in parallel to the datapath, with a one-cycle write-strobe pulse per register.

Parameters:
- DATA_WIDTH, 16, width of each register and of the data buses
- ADDR_WIDTH, 4, request address width; word addressing
- NUM_REGS, 8, number of implemented registers (1..2**ADDR_WIDTH)
- RESET_VALUE, 0, value loaded into every register on reset

Ports:
- clk  input  1  system clock, rising edge
- rsth  input  1  synchronous active-high reset
- req_valid_h  input  1  request valid
- req_ready_h  output  1  responder can accept a request
- req_write_h  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  register index
- req_wdata  input  DATA_WIDTH  write data
- rsp_valid_h  output  1  response valid
- rsp_ready_h  input  1  requester accepts the response
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err_h  output  1  address out of range (addr >= NUM_REGS)
- regs_o  output  NUM_REGS*DATA_WIDTH  flattened register contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- wr_pulse_o  output  NUM_REGS  one-cycle pulse, bit i set the cycle after reg i is written

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rsth), sampled on the rising edge of clk.
- Reset values:
  - all registers = RESET_VALUE
  - state = IDLE; req_ready_h = 0 while rsth = 1
  - rsp_valid_h = 0, rsp_rdata = 0, rsp_err_h = 0, wr_pulse_o = 0
- States: IDLE, RESP.
- IDLE:
  - req_ready_h = 1 (when rsth = 0), rsp_valid_h = 0.
  - Handshake on the edge where req_valid_h & req_ready_h; go to RESP.
- Handshake actions:
  - In-range write: reg[addr] <= req_wdata; rsp_rdata <= 0; rsp_err_h <= 0; wr_pulse_o[addr] <= 1 for exactly one cycle.
  - In-range read: rsp_rdata <= reg[addr] (value before this edge); rsp_err_h <= 0.
  - Out-of-range read or write: no register changes; no wr_pulse; rsp_rdata <= 0; rsp_err_h <= 1.
- RESP:
  - req_ready_h = 0; rsp_valid_h = 1.
  - rsp_rdata and rsp_err_h are held stable until the handshake.
  - On rsp_valid_h & rsp_ready_h: go to IDLE; rsp_rdata and rsp_err_h clear to 0.
- Latency and throughput:
  - Response is valid the first cycle after request acceptance.
  - Peak throughput is one transaction per 2 cycles, with rsp_ready_h held high.
- Backpressure: RESP may last indefinitely; requests presented meanwhile are not accepted and must be held by the requester.
- Request inputs are ignored when req_valid_h = 0.
- regs_o changes on the edge of the write handshake, i.e. it is visible in the same cycle rsp_valid_h rises.
- Reset mid-transaction:
  - rsth in RESP drops the pending response (rsp_valid_h = 0 next cycle) and reloads all registers.
  - rsth coincident with a request handshake: reset wins; no write occurs.
- NUM_REGS = 2**ADDR_WIDTH: no out-of-range addresses exist, and rsp_err_h is never set.

Decomposition:
- Package reg_bank_pkg holds:
  - the state enum (IDLE, RESP), typedef logic
  - the constant encoding of rsp_err_h (OK = 0, ERR_ADDR = 1)
- No sub-module. Storage is an inline array with a synchronous-reset always block, because the existing generic register uses an asynchronous reset and is not reused here.

Test Plan:
1. Reset: hold rsth 3 cycles with req_valid_h = 1 -> req_ready_h = 0, rsp_valid_h = 0, regs_o all zero, wr_pulse_o = 0. Release -> req_ready_h = 1 the next cycle.
2. Write then read:
   - write addr 3 data 0xBEEF -> 1 cycle later rsp_valid_h = 1, rsp_err_h = 0, rsp_rdata = 0, wr_pulse_o = 8'b0000_1000 for one cycle, regs_o[63:48] = 0xBEEF.
   - read addr 3 -> rsp_rdata = 0xBEEF.
3. Out of range (NUM_REGS = 8, ADDR_WIDTH = 4): write addr 9 data 0x1234 -> rsp_err_h = 1, rsp_rdata = 0, regs_o unchanged, wr_pulse_o = 0. Read addr 15 -> rsp_err_h = 1, rsp_rdata = 0.
4. Backpressure:
   - Hold rsp_ready_h = 0 for 5 cycles after a read of addr 0 (value 0x00A5), with a second request asserted -> rsp_valid_h stays 1, rsp_rdata stable at 0x00A5, req_ready_h = 0.
   - Release -> response consumed; second request accepted on the next cycle.
5. Back-to-back with rsp_ready_h = 1 throughout: 4 writes to addrs 0..3 -> one accepted every 2 cycles; 4 responses; wr_pulse_o bits 0..3 pulse in order.
6. Reset mid-transaction: assert rsth while in RESP after a write to addr 2 of 0x5555 -> next cycle rsp_valid_h = 0 and regs_o[47:32] = RESET_VALUE.
